fp32_add_sub: RTL and testbench

Single-precision IEEE-754 floating-point adder/subtractor with a registered result. It computes `a + b` or `a − b` as selected by `symbol`, with round-to-nearest-even and full special-value handling. The core is a combinational unpack/align/add/normalise/round datapath, followed by one output register. It sits in the FPU datapath wherever a scalar fp32 add or subtract is needed. The mantissa adder is a carry-lookahead adder.

---
 rtl/fp32_add_sub.sv | 175 +++++++++++++++++
 tb/tb_fp32_add_sub.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/fp32_add_sub.sv
// fp32_add_sub: IEEE-754 binary32 adder/subtractor with one output register.
// Unpack, align, add/subtract, normalise and round-to-nearest-even are all
// combinational. Subnormal inputs and results are flushed to signed zero.
module fp32_add_sub #(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] a,
   input  logic [DATA_WIDTH-1:0] b,
   input  logic                  symbol,
   output logic [DATA_WIDTH-1:0] out
);

   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   // 27-bit carry-lookahead adder: nine 3-bit groups with group generate and
   // propagate terms, carries inside each group expanded in full.
   function automatic logic [27:0] cla_add27(input logic [26:0] x,
                                             input logic [26:0] y,
                                             input logic        cin);
      logic [26:0] g, p, c;
      logic [8:0]  bg, bp;
      logic [9:0]  bc;
      g = x & y;
      p = x ^ y;
      for (int k = 0; k < 9; k++) begin
         bg[k] = g[3*k+2] | (p[3*k+2] & g[3*k+1]) | (p[3*k+2] & p[3*k+1] & g[3*k]);
         bp[k] = p[3*k+2] & p[3*k+1] & p[3*k];
      end
      bc[0] = cin;
      for (int k = 0; k < 9; k++) begin
         bc[k+1] = bg[k] | (bp[k] & bc[k]);
      end
      for (int k = 0; k < 9; k++) begin
         c[3*k]   = bc[k];
         c[3*k+1] = g[3*k] | (p[3*k] & bc[k]);
         c[3*k+2] = g[3*k+1] | (p[3*k+1] & g[3*k]) | (p[3*k+1] & p[3*k] & bc[k]);
      end
      return {bc[9], p ^ c};
   endfunction

   // Leading-zero count of the 27-bit pre-normalisation magnitude.
   function automatic logic [4:0] lzc27(input logic [26:0] v);
      logic [4:0] n;
      logic       found;
      n     = 5'd0;
      found = 1'b0;
      for (int i = 26; i >= 0; i--) begin
         if (!found) begin
            if (v[i]) found = 1'b1;
            else      n = n + 5'd1;
         end
      end
      return n;
   endfunction

   // Round-to-nearest-even on the 23-bit fraction; returns {mantissa_ovf, frac}.
   function automatic logic [23:0] rne_round(input logic [22:0] f,
                                             input logic        g,
                                             input logic        st);
      logic up;
      up = g & (st | f[0]);
      return {up & (&f), f + {22'd0, up}};
   endfunction

   // Saturate the final exponent: overflow to signed Inf, underflow to signed zero.
   function automatic logic [31:0] pack_result(input logic              sgn,
                                               input logic signed [9:0] e,
                                               input logic [22:0]       f);
      if (e >= 10'sd255)    return {sgn, 8'hFF, 23'd0};
      else if (e <= 10'sd0) return {sgn, 31'd0};
      else                  return {sgn, e[7:0], f};
   endfunction

   logic              a_s, b_s, l_s, s_s, eff_sub;
   logic [7:0]        a_e, b_e, l_e, s_e, d;
   logic [22:0]       a_f, b_f, l_f, s_f;
   logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, a_ge;
   logic [49:0]       wide;
   logic [25:0]       al;
   logic              st;
   logic [26:0]       op_l, op_s, op_y;
   logic [27:0]       cla_r, sum;
   logic [4:0]        lz;
   logic [25:0]       sh;
   logic [22:0]       n_frac;
   logic              n_g, n_st;
   logic signed [9:0] n_exp, r_exp;
   logic [23:0]       rnd;
   logic [31:0]       norm_res, res;

   // Unpack; b carries the operation select folded into its sign.
   assign a_s = a[31];
   assign a_e = a[30:23];
   assign a_f = a[22:0];
   assign b_s = b[31] ^ symbol;
   assign b_e = b[30:23];
   assign b_f = b[22:0];

   assign a_nan  = (a_e == 8'hFF) && (a_f != 23'd0);
   assign b_nan  = (b_e == 8'hFF) && (b_f != 23'd0);
   assign a_inf  = (a_e == 8'hFF) && (a_f == 23'd0);
   assign b_inf  = (b_e == 8'hFF) && (b_f == 23'd0);
   assign a_zero = (a_e == 8'd0);
   assign b_zero = (b_e == 8'd0);

   // L is the operand of larger magnitude, S the smaller one.
   assign a_ge    = ({a_e, a_f} >= {b_e, b_f});
   assign l_s     = a_ge ? a_s : b_s;
   assign l_e     = a_ge ? a_e : b_e;
   assign l_f     = a_ge ? a_f : b_f;
   assign s_s     = a_ge ? b_s : a_s;
   assign s_e     = a_ge ? b_e : a_e;
   assign s_f     = a_ge ? b_f : a_f;
   assign d       = l_e - s_e;
   assign eff_sub = l_s ^ s_s;

   // Align S to L, keeping guard and round bits plus a sticky OR of the rest.
   always_comb begin
      wide = {1'b1, s_f, 26'd0} >> d;
      al   = wide[49:24];
      st   = |wide[23:0];
      if (d >= 8'd26) begin
         al = 26'd0;
         st = 1'b1;
      end
   end

   // Magnitude add or subtract; L >= S so a subtraction never goes negative.
   assign op_l  = {1'b1, l_f, 3'b000};
   assign op_s  = {al, st};
   assign op_y  = eff_sub ? ~op_s : op_s;
   assign cla_r = cla_add27(op_l, op_y, eff_sub);
   assign sum   = {cla_r[27] & ~eff_sub, cla_r[26:0]};

   // Normalise (right by one on carry-out, else left by the leading-zero count) and round.
   always_comb begin
      lz = lzc27(sum[26:0]);
      sh = sum[25:0] << lz;
      if (sum[27]) begin
         n_frac = sum[26:4];
         n_g    = sum[3];
         n_st   = |sum[2:0];
         n_exp  = $signed({2'b00, l_e}) + 10'sd1;
      end else begin
         n_frac = sh[25:3];
         n_g    = sh[2];
         n_st   = |sh[1:0];
         n_exp  = $signed({2'b00, l_e}) - $signed({5'b00000, lz});
      end
      rnd      = rne_round(n_frac, n_g, n_st);
      r_exp    = n_exp + $signed({9'd0, rnd[23]});
      norm_res = (sum == 28'd0) ? 32'd0 : pack_result(l_s, r_exp, rnd[22:0]);
   end

   // Special values take priority over the arithmetic result.
   always_comb begin
      res = norm_res;
      if (a_nan || b_nan)                    res = QNAN;
      else if (a_inf && b_inf && (a_s != b_s)) res = QNAN;
      else if (a_inf)                        res = {a_s, 8'hFF, 23'd0};
      else if (b_inf)                        res = {b_s, 8'hFF, 23'd0};
      else if (a_zero && b_zero)             res = {a_s & b_s, 31'd0};
      else if (a_zero)                       res = {b_s, b[30:0]};
      else if (b_zero)                       res = a;
   end

   // Output register; reset wins over a new result.
   always_ff @(posedge clk) begin
      if (!rst_n) out <= '0;
      else        out <= res;
   end

endmodule

// File: tb/tb_fp32_add_sub.sv
// Testbench for fp32_add_sub: directed vector table, reset sequences and a
// random sweep checked against a real-arithmetic RNE reference.
module tb_fp32_add_sub;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] a, b, out;
   logic        symbol;

   int n_chk  = 0;
   int n_pass = 0;

   typedef struct {
      string       name;
      logic [31:0] a;
      logic [31:0] b;
      logic        sym;
      logic [31:0] exp;
   } vec_t;

   vec_t vt[$];

   always #5 clk = ~clk;

   fp32_add_sub #(.DATA_WIDTH(32)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .a      (a),
      .b      (b),
      .symbol (symbol),
      .out    (out)
   );

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got %h expected %h", name, got, exp);
   endtask

   task automatic apply(input logic [31:0] aa, input logic [31:0] bb, input logic sym);
      a      = aa;
      b      = bb;
      symbol = sym;
      @(posedge clk);
      #1;
   endtask

   task automatic add_vec(input string n, input logic [31:0] aa, input logic [31:0] bb,
                          input logic sym, input logic [31:0] e);
      vec_t v;
      v.name = n;
      v.a    = aa;
      v.b    = bb;
      v.sym  = sym;
      v.exp  = e;
      vt.push_back(v);
   endtask

   function automatic real f2r(input logic [31:0] x);
      logic [10:0] e;
      e = 11'(x[30:23]) + 11'd896;
      return $bitstoreal({x[31], e, x[22:0], 29'd0});
   endfunction

   // Exact double sum (operands chosen so it is exact), then RNE to binary32.
   function automatic logic [31:0] ref_add(input logic [31:0] x, input logic [31:0] y,
                                           input logic sym);
      real         rs, ry;
      logic [63:0] bits;
      logic [24:0] s25;
      logic [28:0] rem;
      logic [8:0]  fe;
      logic        up;
      ry = f2r(y);
      if (sym) ry = -ry;
      rs = f2r(x) + ry;
      if (rs == 0.0) return 32'd0;
      bits = $realtobits(rs);
      rem  = bits[28:0];
      up   = (rem > 29'h1000_0000) || ((rem == 29'h1000_0000) && bits[29]);
      s25  = {2'b01, bits[51:29]} + {24'd0, up};
      fe   = 9'(bits[62:52] - 11'd896);
      if (s25[24]) fe = fe + 9'd1;
      return {bits[63], fe[7:0], s25[22:0]};
   endfunction

   function automatic logic [31:0] rand_op();
      logic [7:0] e;
      e = 8'(115 + $urandom_range(0, 25));
      return {1'($urandom_range(0, 1)), e, 23'($urandom)};
   endfunction

   initial begin
      logic [31:0] ra, rb;
      logic        rsym;

      add_vec("sub_5_7",        32'h40A0_0000, 32'h40E0_0000, 1'b0, 32'h4140_0000);
      add_vec("sub_5_7_neg",    32'h40A0_0000, 32'h40E0_0000, 1'b1, 32'hC000_0000);
      add_vec("neg_round_up",   32'hC179_999A, 32'h406C_CCCD, 1'b0, 32'hC13E_6667);
      add_vec("cancel_zero",    32'h406C_CCCD, 32'h406C_CCCD, 1'b1, 32'h0000_0000);
      add_vec("zero_plus",      32'h0000_0000, 32'h406C_CCCD, 1'b0, 32'h406C_CCCD);
      add_vec("zero_minus",     32'h0000_0000, 32'h406C_CCCD, 1'b1, 32'hC06C_CCCD);
      add_vec("x_minus_zero",   32'h406C_CCCD, 32'h0000_0000, 1'b1, 32'h406C_CCCD);
      add_vec("inf_minus_x",    32'h7F80_0000, 32'h406C_CCCD, 1'b1, 32'h7F80_0000);
      add_vec("inf_minus_inf",  32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7FC0_0000);
      add_vec("inf_plus_inf",   32'h7F80_0000, 32'h7F80_0000, 1'b0, 32'h7F80_0000);
      add_vec("ninf_plus_ninf", 32'hFF80_0000, 32'hFF80_0000, 1'b0, 32'hFF80_0000);
      add_vec("inf_minus_ninf", 32'h7F80_0000, 32'hFF80_0000, 1'b1, 32'h7F80_0000);
      add_vec("x_minus_ninf",   32'h406C_CCCD, 32'hFF80_0000, 1'b1, 32'h7F80_0000);
      add_vec("nan_a_add",      32'hFF80_0001, 32'h406C_CCCD, 1'b0, 32'h7FC0_0000);
      add_vec("nan_a_sub",      32'hFF80_0001, 32'h406C_CCCD, 1'b1, 32'h7FC0_0000);
      add_vec("inf_plus_nan",   32'h7F80_0000, 32'hFF80_0001, 1'b0, 32'h7FC0_0000);
      add_vec("align_sticky",   32'h3F82_0817, 32'h352E_B9ED, 1'b0, 32'h3F82_081C);
      add_vec("far_sub_sticky", 32'h3F7F_E6E7, 32'hAD24_E6F2, 1'b0, 32'h3F7F_E6E7);
      add_vec("overflow_inf",   32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000);
      add_vec("underflow_pos",  32'h0080_0001, 32'h0080_0000, 1'b1, 32'h0000_0000);
      add_vec("underflow_neg",  32'h0080_0000, 32'h0080_0001, 1'b1, 32'h8000_0000);
      add_vec("nzero_nzero",    32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000);
      add_vec("nzero_sub_nz",   32'h8000_0000, 32'h8000_0000, 1'b1, 32'h0000_0000);
      add_vec("subnorm_flush",  32'h0000_0001, 32'h406C_CCCD, 1'b0, 32'h406C_CCCD);
      add_vec("tie_even_down",  32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000);
      add_vec("tie_even_up",    32'h3F80_0001, 32'h3380_0000, 1'b0, 32'h3F80_0002);
      add_vec("round_mant_ovf", 32'h3F7F_FFFF, 32'h3300_0000, 1'b0, 32'h3F80_0000);
      add_vec("carry_norm",     32'h3FC0_0000, 32'h3FC0_0000, 1'b0, 32'h4040_0000);
      add_vec("deep_cancel",    32'h3F80_0000, 32'h3F7F_FFFF, 1'b1, 32'h3380_0000);

      // Reset held for two edges with live operands.
      rst_n  = 1'b0;
      a      = 32'h40A0_0000;
      b      = 32'h40E0_0000;
      symbol = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("reset_out", out, 32'h0000_0000);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("first_after_reset", out, 32'h4140_0000);

      // Back-to-back directed vectors, one per cycle.
      for (int i = 0; i < vt.size(); i++) begin
         apply(vt[i].a, vt[i].b, vt[i].sym);
         check(vt[i].name, out, vt[i].exp);
      end

      // Mid-stream reset discards the in-flight result.
      apply(32'h3FC0_0000, 32'h3FC0_0000, 1'b0);
      check("pre_midreset", out, 32'h4040_0000);
      rst_n = 1'b0;
      apply(32'h40A0_0000, 32'h40E0_0000, 1'b0);
      check("midreset", out, 32'h0000_0000);
      rst_n = 1'b1;
      apply(32'h40A0_0000, 32'h40E0_0000, 1'b1);
      check("post_midreset", out, 32'hC000_0000);

      // Random normal operands, both operations.
      for (int i = 0; i < 2000; i++) begin
         ra   = rand_op();
         rb   = rand_op();
         rsym = 1'($urandom_range(0, 1));
         apply(ra, rb, rsym);
         check("rand_rne", out, ref_add(ra, rb, rsym));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
